// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory port of the prefetch stage.
// Handshake: a request is issued on a rising clk edge where imem_req & imem_ready
// are both 1, and imem_req never depends on imem_ready. imem_rvalid carries no
// back-pressure. One response per issued request, returned in issue order, at the
// earliest one cycle after the issue edge.
interface if_prefetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  // Fetch stage side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  // Memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Fetch stage with an in-order prefetch queue. Requests run ahead of ID until
// the queued plus in-flight words reach DEPTH. A taken branch empties the queue,
// points fetch at the target and squashes every response still in flight.
module if_prefetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] BranchAddr,
  if_prefetch_stage_if.master imem,
  output logic              valid,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] Instruction,
  output logic [0:0]        fsm_state
);

  localparam int                PW        = $clog2(DEPTH);
  localparam int                CW        = PW + 1;
  localparam logic [CW:0]       DEPTH_OCC = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
  localparam logic [CW-1:0]     ONE_C     = CW'(1);
  localparam logic [PW-1:0]     ONE_P     = PW'(1);

  // RUN issues requests; DRAIN waits for squashed responses to come back.
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     squash;
  logic [CW:0]       occupancy;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic              issue;
  logic              drop;
  logic              push;
  logic              pop;

  // Reserve a queue slot for every request in flight so a response always fits.
  assign occupancy   = {1'b0, count} + {1'b0, outstanding};
  assign imem.imem_req  = rst && (state == RUN) && (occupancy < DEPTH_OCC) && !Branch_taken;
  assign imem.imem_addr = fetch_pc;

  assign issue = imem.imem_req & imem.imem_ready;
  assign drop  = (squash != '0);
  assign push  = imem.imem_rvalid & !drop & !Branch_taken;
  assign pop   = valid & !freeze & !Branch_taken;

  // In-flight count after this cycle's issue and response.
  assign outstanding_nxt = outstanding + (issue ? ONE_C : '0) - (imem.imem_rvalid ? ONE_C : '0);

  assign valid       = (count != '0);
  assign PC          = valid ? (q_addr[head] + STEP) : '0;
  assign Instruction = valid ? q_data[head] : '0;
  assign fsm_state   = state;

  // FSM and squash counter: a redirect squashes everything still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      squash <= '0;
    end else if (Branch_taken) begin
      squash <= outstanding_nxt;
      state  <= (outstanding_nxt != '0) ? DRAIN : RUN;
    end else if (imem.imem_rvalid && drop) begin
      squash <= squash - ONE_C;
      if (squash == ONE_C) begin
        state <= RUN;
      end
    end
  end

  // Fetch address, address of the next kept response, and in-flight counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (Branch_taken) begin
        fetch_pc <= BranchAddr;
        rsp_pc   <= BranchAddr;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + STEP;
        end
        if (push) begin
          rsp_pc <= rsp_pc + STEP;
        end
      end
    end
  end

  // Queue pointers and fill count; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (Branch_taken) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + ONE_P;
      end
      if (pop) begin
        head <= head + ONE_P;
      end
      count <= count + (push ? ONE_C : '0) - (pop ? ONE_C : '0);
    end
  end

  // Queue storage: responses carry no address, so rsp_pc supplies it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= rsp_pc;
      q_data[tail] <= imem.imem_rdata;
    end
  end

endmodule
